// File: rtl/lcd_pkg.sv
// Constants and types shared between the LCD text sequencer and the LCD controller.
package lcd_pkg;

   localparam logic [7:0] LINE0_BASE     = 8'h00;
   localparam logic [7:0] LINE1_BASE     = 8'h40;
   localparam logic [7:0] DDRAM_SET_ADDR = 8'h80;
   localparam logic [7:0] CHAR_SPACE     = 8'h20;

   typedef enum logic [2:0] {
      StIdle,
      StLoadAddr,
      StLoadChar,
      StWaitLock,
      StWaitRelease,
      StAdvance
   } seq_state_e;

   function automatic logic [7:0] ddram_addr_cmd(input logic line);
      return DDRAM_SET_ADDR | (line ? LINE1_BASE : LINE0_BASE);
   endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// Item bus between the text sequencer (master) and the LCD controller (slave).
interface lcd_text_sequencer_if;

   logic       bus_lock;
   logic       addr_or_data;
   logic [7:0] data_out;

   modport master (
      input  bus_lock,
      output addr_or_data,
      output data_out
   );

   modport slave (
      output bus_lock,
      input  addr_or_data,
      input  data_out
   );

endinterface

// File: rtl/lcd_text_buffer.sv
// 32x8 frame buffer: one write port, registered read with enable, sweeps itself to spaces after reset.
module lcd_text_buffer
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_we,
   input  logic [4:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic       i_re,
   input  logic [4:0] i_raddr,
   output logic [7:0] o_rdata,
   output logic       o_init_busy
);

   logic [7:0] r_mem [32];
   logic [7:0] r_rdata;
   logic [4:0] r_init_cnt;
   logic       r_init_active;
   logic       w_we;
   logic [4:0] w_waddr;
   logic [7:0] w_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_init_cnt    <= '0;
         r_init_active <= 1'b1;
      end else if (r_init_active) begin
         r_init_cnt <= r_init_cnt + 5'd1;
         if (r_init_cnt == 5'(DEPTH - 1)) begin
            r_init_active <= 1'b0;
         end
      end
   end

   // The sweep owns the write port; host writes during it are dropped.
   assign w_we    = r_init_active | (i_we & (32'(i_waddr) < DEPTH));
   assign w_waddr = r_init_active ? r_init_cnt : i_waddr;
   assign w_wdata = r_init_active ? CHAR_SPACE : i_wdata;

   // Read and write in one block so a same-index collision returns the old byte.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata     = r_rdata;
   assign o_init_busy = r_init_active & ~reset;

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams a 2x16 text frame to the LCD controller as address/data items paced by bus_lock.
module lcd_text_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned LINE_LEN       = 16,
   parameter int unsigned NUM_LINES      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_char_we,
   input  logic [4:0]           i_char_addr,
   input  logic [7:0]           i_char_data,
   input  logic                 i_refresh_req,
   lcd_text_sequencer_if.master ctrl,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic                 o_error_flag
);

   localparam int unsigned      COL_W     = $clog2(LINE_LEN);
   localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(LINE_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_e       r_state, w_state;
   logic             r_line, w_line;
   logic [COL_W-1:0] r_col, w_col;
   logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt;
   logic             r_pending, w_pending;
   logic             r_busy, w_busy;
   logic             r_frame_done, w_frame_done;
   logic             r_error, w_error;
   logic             r_addr_or_data, w_addr_or_data;
   logic [7:0]       r_addr_byte, w_addr_byte;
   logic             w_timeout;
   logic             w_re;
   logic [4:0]       w_raddr;
   logic [7:0]       w_rdata;
   logic             w_init_busy;

   lcd_text_buffer #(
      .DEPTH (NUM_LINES * LINE_LEN)
   ) u_buffer (
      .clk         (clk),
      .reset       (reset),
      .i_we        (i_char_we),
      .i_waddr     (i_char_addr),
      .i_wdata     (i_char_data),
      .i_re        (w_re),
      .i_raddr     (w_raddr),
      .o_rdata     (w_rdata),
      .o_init_busy (w_init_busy)
   );

   // Read is issued on the way out of ADVANCE, so it targets the next counter values.
   assign w_raddr = 5'(32'(w_line) * LINE_LEN + 32'(w_col));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= StIdle;
         r_line         <= 1'b0;
         r_col          <= '0;
         r_wait_cnt     <= '0;
         r_pending      <= 1'b0;
         r_busy         <= 1'b0;
         r_frame_done   <= 1'b0;
         r_error        <= 1'b0;
         r_addr_or_data <= 1'b0;
         r_addr_byte    <= 8'h00;
      end else begin
         r_state        <= w_state;
         r_line         <= w_line;
         r_col          <= w_col;
         r_wait_cnt     <= w_wait_cnt;
         r_pending      <= w_pending;
         r_busy         <= w_busy;
         r_frame_done   <= w_frame_done;
         r_error        <= w_error;
         r_addr_or_data <= w_addr_or_data;
         r_addr_byte    <= w_addr_byte;
      end
   end

   always_comb begin
      w_state        = r_state;
      w_line         = r_line;
      w_col          = r_col;
      w_wait_cnt     = r_wait_cnt;
      w_pending      = r_pending | i_refresh_req;
      w_busy         = r_busy;
      w_frame_done   = 1'b0;
      w_error        = r_error;
      w_addr_or_data = r_addr_or_data;
      w_addr_byte    = r_addr_byte;
      w_timeout      = 1'b0;
      w_re           = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (!w_init_busy && (i_refresh_req || r_pending)) begin
               w_state        = StLoadAddr;
               w_busy         = 1'b1;
               w_pending      = 1'b0;
               w_addr_or_data = 1'b0;
               w_addr_byte    = ddram_addr_cmd(1'b0);
            end
         end
         StLoadAddr, StLoadChar: begin
            w_state    = StWaitLock;
            w_wait_cnt = '0;
         end
         StWaitLock: begin
            if (ctrl.bus_lock) begin
               w_state    = StWaitRelease;
               w_wait_cnt = '0;
            end else if (r_wait_cnt == LAST_WAIT) begin
               w_timeout = 1'b1;
            end else begin
               w_wait_cnt = r_wait_cnt + 1'b1;
            end
         end
         StWaitRelease: begin
            if (!ctrl.bus_lock) begin
               w_state = StAdvance;
            end else if (r_wait_cnt == LAST_WAIT) begin
               w_timeout = 1'b1;
            end else begin
               w_wait_cnt = r_wait_cnt + 1'b1;
            end
         end
         StAdvance: begin
            if (!r_addr_or_data) begin
               w_state        = StLoadChar;
               w_col          = '0;
               w_re           = 1'b1;
               w_addr_or_data = 1'b1;
            end else if (r_col != LAST_COL) begin
               w_state = StLoadChar;
               w_col   = r_col + 1'b1;
               w_re    = 1'b1;
            end else if (32'(r_line) + 32'd1 < NUM_LINES) begin
               w_state        = StLoadAddr;
               w_line         = r_line + 1'b1;
               w_col          = '0;
               w_addr_or_data = 1'b0;
               w_addr_byte    = ddram_addr_cmd(w_line);
            end else begin
               w_state      = StIdle;
               w_busy       = 1'b0;
               w_frame_done = 1'b1;
               w_line       = 1'b0;
               w_col        = '0;
            end
         end
         default: w_state = StIdle;
      endcase

      if (w_timeout) begin
         w_state    = StIdle;
         w_error    = 1'b1;
         w_busy     = 1'b0;
         w_line     = 1'b0;
         w_col      = '0;
         w_wait_cnt = '0;
      end
   end

   assign ctrl.addr_or_data = r_addr_or_data;
   assign ctrl.data_out     = r_addr_or_data ? w_rdata : r_addr_byte;
   assign o_busy            = r_busy | w_init_busy;
   assign o_frame_done      = r_frame_done;
   assign o_error_flag      = r_error;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Bench for lcd_text_sequencer: controller model doubles as item monitor against a scoreboard queue.
module tb_lcd_text_sequencer;

   logic       clk;
   logic       reset;
   logic       char_we;
   logic [4:0] char_addr;
   logic [7:0] char_data;
   logic       refresh_req;
   logic       busy;
   logic       frame_done;
   logic       error_flag;

   lcd_text_sequencer_if bus_if ();

   lcd_text_sequencer #(
      .LINE_LEN       (16),
      .NUM_LINES      (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_char_we     (char_we),
      .i_char_addr   (char_addr),
      .i_char_data   (char_data),
      .i_refresh_req (refresh_req),
      .ctrl          (bus_if),
      .o_busy        (busy),
      .o_frame_done  (frame_done),
      .o_error_flag  (error_flag)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         items_seen = 0;
   int         fd_cnt = 0;
   logic       ctrl_en = 1'b0;
   logic       early_lock = 1'b0;
   logic [8:0] exp_q [$];
   logic [7:0] model_buf [32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
   end

   // Controller model: holds bus_lock 3 cycles per item; in early mode re-raises it before the load.
   initial begin
      logic [8:0] got;
      logic [8:0] want;
      bus_if.bus_lock = 1'b0;
      forever begin
         @(negedge clk);
         if (ctrl_en && busy) begin
            got = {bus_if.addr_or_data, bus_if.data_out};
            items_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL item%0d: unexpected item aod=%0b data=%02h", items_seen, got[8],
                        got[7:0]);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_errors++;
                  $display("FAIL item%0d: got aod=%0b data=%02h, want aod=%0b data=%02h",
                           items_seen, got[8], got[7:0], want[8], want[7:0]);
               end
            end
            bus_if.bus_lock = 1'b1;
            repeat (3) @(negedge clk);
            bus_if.bus_lock = 1'b0;
            @(negedge clk);
            if (early_lock) bus_if.bus_lock = 1'b1;
            repeat (2) @(negedge clk);
         end else begin
            bus_if.bus_lock = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic write_char(input int idx, input logic [7:0] ch);
      char_we   = 1'b1;
      char_addr = 5'(idx);
      char_data = ch;
      @(negedge clk);
      char_we = 1'b0;
      model_buf[idx] = ch;
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   task automatic push_frame();
      exp_q.push_back({1'b0, 8'h80});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model_buf[c]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model_buf[16 + c]});
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
   endtask

   task automatic wait_fd(input int target, input int budget, input string name);
      int cyc = 0;
      while (fd_cnt < target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(fd_cnt >= target), 32'd1);
   endtask

   task automatic wait_items(input int target, input int budget, input string name);
      int cyc = 0;
      while (items_seen < target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(items_seen >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int cyc = 0;
      while (busy && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: simulation did not finish, items=%0d", items_seen);
      $fatal(1);
   end

   initial begin
      int fd0;
      int it0;
      reset       = 1'b1;
      char_we     = 1'b0;
      char_addr   = '0;
      char_data   = '0;
      refresh_req = 1'b0;
      clear_model();

      repeat (3) @(negedge clk);
      check("rst_aod", 32'(bus_if.addr_or_data), 32'd0);
      check("rst_data", 32'(bus_if.data_out), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_error", 32'(error_flag), 32'd0);

      reset = 1'b0;
      repeat (31) @(negedge clk);
      check("sweep_busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      check("sweep_busy_clear", 32'(busy), 32'd0);
      ctrl_en = 1'b1;

      // HELLO frame
      write_char(0, "H");
      write_char(1, "E");
      write_char(2, "L");
      write_char(3, "L");
      write_char(4, "O");
      push_frame();
      fd0 = fd_cnt;
      it0 = items_seen;
      pulse_refresh();
      wait_fd(fd0 + 1, 2000, "hello_frame_done");
      repeat (20) @(negedge clk);
      check("hello_fd_count", 32'(fd_cnt - fd0), 32'd1);
      check("hello_items", 32'(items_seen - it0), 32'd34);
      check("hello_busy_after", 32'(busy), 32'd0);
      check("hello_queue_empty", 32'(exp_q.size()), 32'd0);

      // bus_lock already high when each item loads
      early_lock = 1'b1;
      push_frame();
      fd0 = fd_cnt;
      pulse_refresh();
      wait_fd(fd0 + 1, 2000, "early_frame_done");
      repeat (20) @(negedge clk);
      early_lock = 1'b0;
      check("early_error", 32'(error_flag), 32'd0);
      check("early_queue_empty", 32'(exp_q.size()), 32'd0);

      // write index 5 while its item is in flight
      push_frame();
      fd0 = fd_cnt;
      it0 = items_seen;
      pulse_refresh();
      wait_items(it0 + 7, 500, "wr_reach_item");
      repeat (2) @(negedge clk);
      write_char(5, "X");
      wait_fd(fd0 + 1, 2000, "wr_frame1_done");
      push_frame();
      pulse_refresh();
      wait_fd(fd0 + 2, 2000, "wr_frame2_done");
      repeat (20) @(negedge clk);
      check("wr_queue_empty", 32'(exp_q.size()), 32'd0);

      // three requests during a transfer collapse into one extra frame
      push_frame();
      push_frame();
      fd0 = fd_cnt;
      it0 = items_seen;
      pulse_refresh();
      wait_items(it0 + 5, 500, "multi_reach5");
      pulse_refresh();
      wait_items(it0 + 15, 500, "multi_reach15");
      pulse_refresh();
      wait_items(it0 + 30, 500, "multi_reach30");
      pulse_refresh();
      wait_fd(fd0 + 2, 4000, "multi_frames_done");
      repeat (60) @(negedge clk);
      check("multi_fd_count", 32'(fd_cnt - fd0), 32'd2);
      check("multi_items", 32'(items_seen - it0), 32'd68);
      check("multi_busy_after", 32'(busy), 32'd0);
      check("multi_queue_empty", 32'(exp_q.size()), 32'd0);

      // asynchronous reset in the middle of line 1
      push_frame();
      it0 = items_seen;
      pulse_refresh();
      wait_items(it0 + 20, 500, "midrst_reach_line1");
      ctrl_en = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("midrst_aod", 32'(bus_if.addr_or_data), 32'd0);
      check("midrst_data", 32'(bus_if.data_out), 32'h00);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_frame_done", 32'(frame_done), 32'd0);
      check("midrst_error", 32'(error_flag), 32'd0);
      exp_q.delete();
      repeat (5) @(negedge clk);
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      check("midrst_sweep_busy", 32'(busy), 32'd1);
      wait_idle(60, "midrst_sweep_end");
      ctrl_en = 1'b1;
      push_frame();
      fd0 = fd_cnt;
      pulse_refresh();
      wait_fd(fd0 + 1, 2000, "midrst_frame_done");
      repeat (20) @(negedge clk);
      check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

      // handshake timeout: nobody ever raises bus_lock
      ctrl_en = 1'b0;
      repeat (5) @(negedge clk);
      fd0 = fd_cnt;
      pulse_refresh();
      repeat (100) @(negedge clk);
      check("to_before_error", 32'(error_flag), 32'd0);
      check("to_before_busy", 32'(busy), 32'd1);
      check("to_hold_data", 32'(bus_if.data_out), 32'h80);
      @(negedge clk);
      check("to_error_set", 32'(error_flag), 32'd1);
      check("to_busy_clear", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("to_error_sticky", 32'(error_flag), 32'd1);
      check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);

      reset = 1'b1;
      #1;
      check("final_rst_error", 32'(error_flag), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
